// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the read/write channel
// state encodings used by the RAM slave.
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_VALID
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVEA,
    W_HAVED,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/sram_1r1w_be.sv
// Word-wide RAM with one synchronous read port and one byte-enabled
// synchronous write port; a same-edge read of the written word sees old data.
module sram_1r1w_be #(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_strb
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // NOTE: the array has no reset; clearing it would force a flop-based
  // implementation instead of a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // NOTE: non-blocking assignments make the read sample mem before the
  // same-edge write lands, which is what gives read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axi4lite_ram_slave.sv
// AXI4-Lite RAM slave with independent read and write channels.
// Define AXI_RAM_DECERR_EN to answer accesses outside the BASE_ADDR window with DECERR.
module axi4lite_ram_slave
  import axi_lite_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        AWvalid,
  output logic        AWready,
  input  logic [31:0] AWdata,
  input  logic [2:0]  awprot,
  input  logic        Wvalid,
  output logic        Wready,
  input  logic [31:0] Wdata,
  input  logic [3:0]  Wstrb,
  output logic        Bvalid,
  input  logic        Bready,
  output logic [1:0]  Bresp,
  input  logic        ARvalid,
  output logic        ARready,
  input  logic [31:0] ARdata,
  input  logic [2:0]  arprot,
  output logic        Rvalid,
  input  logic        RReady,
  output logic [31:0] Rdata,
  output logic [1:0]  Rresp
);

  localparam int IDX_MSB = ADDR_WIDTH + 1;

  rd_state_e rd_state, rd_next;
  wr_state_e wr_state, wr_next;

  logic                  ar_hs, aw_hs, w_hs, wr_commit;
  logic                  ar_ok, aw_ok_in, aw_ok_q, wr_ok;
  logic [ADDR_WIDTH-1:0] aw_idx_q, wr_idx;
  logic [31:0]           w_data_q, wr_data, ram_q;
  logic [3:0]            w_strb_q, wr_strb;
  resp_t                 bresp_q, rresp_q;
  logic                  unused_bits;

`ifdef AXI_RAM_DECERR_EN
  assign ar_ok    = (ARdata[31:IDX_MSB+1] == BASE_ADDR[31:IDX_MSB+1]);
  assign aw_ok_in = (AWdata[31:IDX_MSB+1] == BASE_ADDR[31:IDX_MSB+1]);
`else
  assign ar_ok    = 1'b1;
  assign aw_ok_in = 1'b1;
`endif

  assign unused_bits = ^{awprot, arprot, AWdata[1:0], ARdata[1:0],
                         AWdata[31:IDX_MSB+1], ARdata[31:IDX_MSB+1], BASE_ADDR};

  // Read channel
  assign ARready = (rd_state == R_IDLE);
  assign Rvalid  = (rd_state == R_VALID);
  assign ar_hs   = ARvalid & ARready;
  assign Rresp   = rresp_q;
  assign Rdata   = (rresp_q == RESP_DECERR) ? 32'h0 : ram_q;

  // NOTE: next state is defaulted first so no path through the case infers a latch.
  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs)  rd_next = R_VALID;
      R_VALID: if (RReady) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_state <= R_IDLE;
      rresp_q  <= RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) rresp_q <= ar_ok ? RESP_OKAY : RESP_DECERR;
    end
  end

  // Write channel
  assign AWready = (wr_state == W_IDLE) || (wr_state == W_HAVED);
  assign Wready  = (wr_state == W_IDLE) || (wr_state == W_HAVEA);
  assign Bvalid  = (wr_state == W_RESP);
  assign Bresp   = bresp_q;
  assign aw_hs   = AWvalid & AWready;
  assign w_hs    = Wvalid & Wready;

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE: begin
        if (aw_hs && w_hs) wr_next = W_RESP;
        else if (aw_hs)    wr_next = W_HAVEA;
        else if (w_hs)     wr_next = W_HAVED;
      end
      W_HAVEA: if (w_hs)   wr_next = W_RESP;
      W_HAVED: if (aw_hs)  wr_next = W_RESP;
      W_RESP:  if (Bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // The half that completes the pair comes straight from the bus this cycle.
  assign wr_commit = (wr_next == W_RESP) && (wr_state != W_RESP);
  assign wr_idx    = (wr_state == W_HAVEA) ? aw_idx_q : AWdata[IDX_MSB:2];
  assign wr_ok     = (wr_state == W_HAVEA) ? aw_ok_q  : aw_ok_in;
  assign wr_data   = (wr_state == W_HAVED) ? w_data_q : Wdata;
  assign wr_strb   = (wr_state == W_HAVED) ? w_strb_q : Wstrb;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_state <= W_IDLE;
      aw_idx_q <= '0;
      aw_ok_q  <= 1'b1;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      wr_state <= wr_next;
      if (aw_hs) begin
        aw_idx_q <= AWdata[IDX_MSB:2];
        aw_ok_q  <= aw_ok_in;
      end
      if (w_hs) begin
        w_data_q <= Wdata;
        w_strb_q <= Wstrb;
      end
      if (wr_commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_DECERR;
    end
  end

  sram_1r1w_be #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk     (clock),
    .rst_n   (resetn),
    .rd_en   (ar_hs),
    .rd_addr (ARdata[IDX_MSB:2]),
    .rd_data (ram_q),
    .wr_en   (wr_commit & wr_ok),
    .wr_addr (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

endmodule
